// File: rtl/event_blinker.sv
// event_blinker
//   Turns single-cycle event pulses into human-visible blinks on an
//   active-low LED. Each accepted event produces one blink: ON_CYCLES lit,
//   then GAP_CYCLES dark. Events that arrive while a blink is running are
//   queued in a saturating pending counter. An event that arrives while the
//   counter is full is dropped and flagged with a one-cycle overflow pulse.
//
// Ports
//   clk       in   1       single clock, rising edge
//   rst       in   1       synchronous, active-high reset
//   event_in  in   1       event pulse; every high cycle counts as one event
//   led_n     out  1       LED drive, active low (0 = lit)
//   busy      out  1       high whenever the blinker is not idle
//   pending   out  PEND_W  queued events not yet blinked
//   overflow  out  1       one-cycle pulse: an event was dropped
//
// All outputs are registered.

module event_blinker #(
  parameter int ON_CYCLES  = 16,
  parameter int GAP_CYCLES = 16,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_in,
  output logic              led_n,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     w_timer_nxt;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_pending_nxt;
  logic              r_led_n;
  logic              r_busy;
  logic              r_overflow;
  logic              w_overflow_nxt;

  logic              w_timer_last;
  logic              w_pend_full;
  logic              w_pend_empty;

  // The timer holds the number of cycles remaining in the current state,
  // including the present one, so a value of 1 marks the last cycle.
  assign w_timer_last = (r_timer == TW'(1));
  assign w_pend_full  = (r_pending == '1);
  assign w_pend_empty = (r_pending == '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer - TW'(1);
    w_pending_nxt  = r_pending;
    w_overflow_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt   = '0;
        w_pending_nxt = '0;
        // The event that wakes the blinker is consumed directly.
        if (event_in) begin
          w_state_nxt = S_ON;
          w_timer_nxt = TW'(ON_CYCLES);
        end
      end

      S_ON: begin
        if (w_timer_last) begin
          w_state_nxt = S_GAP;
          w_timer_nxt = TW'(GAP_CYCLES);
        end
        if (event_in) begin
          if (w_pend_full) begin
            w_overflow_nxt = 1'b1;
          end else begin
            w_pending_nxt = r_pending + PEND_W'(1);
          end
        end
      end

      S_GAP: begin
        if (w_timer_last) begin
          // A live event on the final gap cycle starts the next blink
          // itself, so the queue is left untouched in that case.
          if (event_in) begin
            w_state_nxt = S_ON;
            w_timer_nxt = TW'(ON_CYCLES);
          end else if (!w_pend_empty) begin
            w_state_nxt   = S_ON;
            w_timer_nxt   = TW'(ON_CYCLES);
            w_pending_nxt = r_pending - PEND_W'(1);
          end else begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
          end
        end else if (event_in) begin
          if (w_pend_full) begin
            w_overflow_nxt = 1'b1;
          end else begin
            w_pending_nxt = r_pending + PEND_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_timer_nxt   = '0;
        w_pending_nxt = '0;
      end
    endcase
  end

  // LED and busy are decoded from the next state so they line up with the
  // state register instead of lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_pending  <= '0;
      r_led_n    <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_pending  <= w_pending_nxt;
      r_led_n    <= (w_state_nxt != S_ON);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_overflow <= w_overflow_nxt;
    end
  end

  assign led_n    = r_led_n;
  assign busy     = r_busy;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker. Two instances share clock and reset:
// u_dut_a (ON=4, GAP=2, PEND_W=2) and u_dut_b (ON=4, GAP=2, PEND_W=3).
// Stimulus pushes hand-computed expected blink start cycles and output
// snapshots into queues; an independent monitor pops and compares them.
// Cycle k is the interval between rising edge k and rising edge k+1.

module tb_event_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev_a = 1'b0;
  logic       ev_b = 1'b0;
  logic       led_a, busy_a, ovf_a;
  logic [1:0] pend_a;
  logic       led_b, busy_b, ovf_b;
  logic [2:0] pend_b;

  always #5 clk = ~clk;

  event_blinker #(.ON_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .event_in (ev_a),
    .led_n    (led_a),
    .busy     (busy_a),
    .pending  (pend_a),
    .overflow (ovf_a)
  );

  event_blinker #(.ON_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .event_in (ev_b),
    .led_n    (led_b),
    .busy     (busy_b),
    .pending  (pend_b),
    .overflow (ovf_b)
  );

  typedef struct {
    string name;
    int    cyc;
    int    sel;
    logic  led_n;
    logic  busy;
    int    pend;
    logic  ovf;
  } chk_t;

  chk_t cq[$];
  int   bq_a[$];
  int   bq_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base = 0;
  bit   mon_en = 1'b0;
  logic prev_a = 1'b1;
  logic prev_b = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_state(input string name, input int sel, input int n,
                              input logic l, input logic b, input int p,
                              input logic o);
    chk_t c;
    c.name  = name;
    c.cyc   = base + n;
    c.sel   = sel;
    c.led_n = l;
    c.busy  = b;
    c.pend  = p;
    c.ovf   = o;
    cq.push_back(c);
  endtask

  task automatic expect_blink(input int sel, input int n);
    if (sel == 0) bq_a.push_back(base + n);
    else          bq_b.push_back(base + n);
  endtask

  task automatic go_to(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    base = cyc;
    rst  = 1'b1;
    go_to(2);
    rst  = 1'b0;
  endtask

  // Monitor: blink starts (led_n falling) and scheduled output snapshots.
  always @(negedge clk) begin
    chk_t c;
    int   e;
    logic al, ab, ao;
    int   ap;
    if (mon_en) begin
      if (prev_a && !led_a) begin
        checks++;
        if (bq_a.size() == 0) begin
          errors++;
          $display("FAIL blink_a: unexpected blink start at cycle %0d", cyc);
        end else begin
          e = bq_a.pop_front();
          if (e != cyc) begin
            errors++;
            $display("FAIL blink_a: blink started at cycle %0d, expected %0d", cyc, e);
          end
        end
      end
      if (prev_b && !led_b) begin
        checks++;
        if (bq_b.size() == 0) begin
          errors++;
          $display("FAIL blink_b: unexpected blink start at cycle %0d", cyc);
        end else begin
          e = bq_b.pop_front();
          if (e != cyc) begin
            errors++;
            $display("FAIL blink_b: blink started at cycle %0d, expected %0d", cyc, e);
          end
        end
      end
      while (cq.size() > 0 && cq[0].cyc <= cyc) begin
        c = cq.pop_front();
        checks++;
        if (c.cyc < cyc) begin
          errors++;
          $display("FAIL %s: snapshot for cycle %0d was skipped", c.name, c.cyc);
        end else begin
          if (c.sel == 0) begin
            al = led_a; ab = busy_a; ap = int'(pend_a); ao = ovf_a;
          end else begin
            al = led_b; ab = busy_b; ap = int'(pend_b); ao = ovf_b;
          end
          if (al !== c.led_n || ab !== c.busy || ap != c.pend || ao !== c.ovf) begin
            errors++;
            $display("FAIL %s: cycle %0d got led_n=%b busy=%b pending=%0d overflow=%b, expected led_n=%b busy=%b pending=%0d overflow=%b",
                     c.name, cyc - base, al, ab, ap, ao, c.led_n, c.busy, c.pend, c.ovf);
          end
        end
      end
    end
    prev_a = led_a;
    prev_b = led_b;
  end

  initial begin
    // Test 1: single event at 10
    start_test();
    mon_en = 1'b1;
    expect_state("t1_reset", 0, 2, 1'b1, 1'b0, 0, 1'b0);
    expect_state("t1_reset_b", 1, 2, 1'b1, 1'b0, 0, 1'b0);
    expect_state("t1_c10", 0, 10, 1'b1, 1'b0, 0, 1'b0);
    expect_state("t1_c11", 0, 11, 1'b0, 1'b1, 0, 1'b0);
    expect_state("t1_c14", 0, 14, 1'b0, 1'b1, 0, 1'b0);
    expect_state("t1_c15", 0, 15, 1'b1, 1'b1, 0, 1'b0);
    expect_state("t1_c16", 0, 16, 1'b1, 1'b1, 0, 1'b0);
    expect_state("t1_c17", 0, 17, 1'b1, 1'b0, 0, 1'b0);
    expect_blink(0, 11);
    go_to(10); ev_a = 1'b1; go_to(11); ev_a = 1'b0;
    go_to(40);

    // Test 2: queueing, events at 10, 12, 13
    start_test();
    expect_state("t2_c13", 0, 13, 1'b0, 1'b1, 1, 1'b0);
    expect_state("t2_c14", 0, 14, 1'b0, 1'b1, 2, 1'b0);
    expect_state("t2_c16", 0, 16, 1'b1, 1'b1, 2, 1'b0);
    expect_state("t2_c17", 0, 17, 1'b0, 1'b1, 1, 1'b0);
    expect_state("t2_c23", 0, 23, 1'b0, 1'b1, 0, 1'b0);
    expect_state("t2_c28", 0, 28, 1'b1, 1'b1, 0, 1'b0);
    expect_state("t2_c29", 0, 29, 1'b1, 1'b0, 0, 1'b0);
    expect_blink(0, 11);
    expect_blink(0, 17);
    expect_blink(0, 23);
    go_to(10); ev_a = 1'b1; go_to(11); ev_a = 1'b0;
    go_to(12); ev_a = 1'b1; go_to(14); ev_a = 1'b0;
    go_to(40);

    // Test 3: saturation, events at 10..14
    start_test();
    expect_state("t3_c14", 0, 14, 1'b0, 1'b1, 3, 1'b0);
    expect_state("t3_c15", 0, 15, 1'b1, 1'b1, 3, 1'b1);
    expect_state("t3_c16", 0, 16, 1'b1, 1'b1, 3, 1'b0);
    expect_state("t3_c17", 0, 17, 1'b0, 1'b1, 2, 1'b0);
    expect_state("t3_c34", 0, 34, 1'b1, 1'b1, 0, 1'b0);
    expect_state("t3_c35", 0, 35, 1'b1, 1'b0, 0, 1'b0);
    expect_blink(0, 11);
    expect_blink(0, 17);
    expect_blink(0, 23);
    expect_blink(0, 29);
    go_to(10); ev_a = 1'b1; go_to(15); ev_a = 1'b0;
    go_to(40);

    // Test 4: event on the last GAP cycle
    start_test();
    expect_state("t4_c16", 0, 16, 1'b1, 1'b1, 0, 1'b0);
    expect_state("t4_c17", 0, 17, 1'b0, 1'b1, 0, 1'b0);
    expect_state("t4_c20", 0, 20, 1'b0, 1'b1, 0, 1'b0);
    expect_state("t4_c21", 0, 21, 1'b1, 1'b1, 0, 1'b0);
    expect_state("t4_c23", 0, 23, 1'b1, 1'b0, 0, 1'b0);
    expect_blink(0, 11);
    expect_blink(0, 17);
    go_to(10); ev_a = 1'b1; go_to(11); ev_a = 1'b0;
    go_to(16); ev_a = 1'b1; go_to(17); ev_a = 1'b0;
    go_to(40);

    // Test 5: reset mid-ON, then a fresh event at 20
    start_test();
    expect_state("t5_c13", 0, 13, 1'b0, 1'b1, 2, 1'b0);
    expect_state("t5_c14", 0, 14, 1'b1, 1'b0, 0, 1'b0);
    expect_state("t5_c18", 0, 18, 1'b1, 1'b0, 0, 1'b0);
    expect_state("t5_c21", 0, 21, 1'b0, 1'b1, 0, 1'b0);
    expect_state("t5_c24", 0, 24, 1'b0, 1'b1, 0, 1'b0);
    expect_state("t5_c25", 0, 25, 1'b1, 1'b1, 0, 1'b0);
    expect_state("t5_c27", 0, 27, 1'b1, 1'b0, 0, 1'b0);
    expect_blink(0, 11);
    expect_blink(0, 21);
    go_to(10); ev_a = 1'b1; go_to(13); ev_a = 1'b0;
    rst = 1'b1; go_to(14); rst = 1'b0;
    go_to(20); ev_a = 1'b1; go_to(21); ev_a = 1'b0;
    go_to(40);

    // Test 6: held input 10..13 on the PEND_W=3 instance
    start_test();
    expect_state("t6_c14", 1, 14, 1'b0, 1'b1, 3, 1'b0);
    expect_state("t6_c15", 1, 15, 1'b1, 1'b1, 3, 1'b0);
    expect_state("t6_c16", 1, 16, 1'b1, 1'b1, 3, 1'b0);
    expect_state("t6_c17", 1, 17, 1'b0, 1'b1, 2, 1'b0);
    expect_state("t6_c23", 1, 23, 1'b0, 1'b1, 1, 1'b0);
    expect_state("t6_c35", 1, 35, 1'b1, 1'b0, 0, 1'b0);
    expect_blink(1, 11);
    expect_blink(1, 17);
    expect_blink(1, 23);
    expect_blink(1, 29);
    go_to(10); ev_b = 1'b1; go_to(14); ev_b = 1'b0;
    go_to(45);

    checks++;
    if (cq.size() != 0) begin
      errors++;
      $display("FAIL snapshots_left: %0d unchecked, expected 0", cq.size());
    end
    checks++;
    if (bq_a.size() != 0) begin
      errors++;
      $display("FAIL blinks_a_left: %0d missing blinks, expected 0", bq_a.size());
    end
    checks++;
    if (bq_b.size() != 0) begin
      errors++;
      $display("FAIL blinks_b_left: %0d missing blinks, expected 0", bq_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
